// File: rtl/tour_cmd.sv
// tour_cmd: walks the knight's-tour move list and turns each knight move into
// a vertical-leg then a horizontal-leg move command for cmd_proc, using the
// same cmd/cmd_rdy/clr_cmd_rdy/send_resp handshake. In IDLE the UART command
// stream passes straight through to cmd_proc.
// Build option: define TOUR_FANFARE_EN to send horizontal legs with the
// move+fanfare opcode (4'h3) so a fanfare plays after every knight move.
module tour_cmd #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    typedef enum logic [2:0] {IDLE, LOAD, VERT, VWAIT, HORZ, HWAIT} state_t;

    localparam logic [3:0] OP_MOVE = 4'h2;
`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] OP_HORZ = 4'h3;
`else
    localparam logic [3:0] OP_HORZ = 4'h2;
`endif
    localparam logic [7:0] HDG_N     = 8'h00;
    localparam logic [7:0] HDG_W     = 8'h3F;
    localparam logic [7:0] HDG_S     = 8'h7F;
    localparam logic [7:0] HDG_E     = 8'hBF;
    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);
    localparam logic [7:0] RESP_BUSY = 8'hA5;
    localparam logic [7:0] RESP_DONE = 8'h5A;

    state_t      state, state_n;
    logic [7:0]  mv_reg;
    logic [15:0] cmd_fsm;
    logic        cmd_rdy_fsm;
    logic        clr_indx, inc_indx, ld_vert, ld_horz, tour_done;

    // Lowest set bit of the move byte; a move with several bits set resolves
    // to its lowest one.
    function automatic logic [2:0] low_bit(input logic [7:0] m);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) k = 3'(i);
        end
        return k;
    endfunction

    // Vertical leg: north when dy>0, south otherwise, |dy| squares.
    function automatic logic [15:0] vert_cmd(input logic [7:0] m);
        logic [15:0] c;
        case (low_bit(m))
            3'd0, 3'd1: c = {OP_MOVE, HDG_N, 4'd2};
            3'd2, 3'd7: c = {OP_MOVE, HDG_N, 4'd1};
            3'd3, 3'd6: c = {OP_MOVE, HDG_S, 4'd1};
            default:    c = {OP_MOVE, HDG_S, 4'd2};
        endcase
        return c;
    endfunction

    // Horizontal leg: east when dx>0, west otherwise, |dx| squares.
    function automatic logic [15:0] horz_cmd(input logic [7:0] m);
        logic [15:0] c;
        case (low_bit(m))
            3'd0, 3'd5: c = {OP_HORZ, HDG_E, 4'd1};
            3'd1, 3'd4: c = {OP_HORZ, HDG_W, 4'd1};
            3'd2, 3'd3: c = {OP_HORZ, HDG_W, 4'd2};
            default:    c = {OP_HORZ, HDG_E, 4'd2};
        endcase
        return c;
    endfunction

    // Next-state logic plus the strobes that update index and command registers.
    always_comb begin
        state_n   = state;
        clr_indx  = 1'b0;
        inc_indx  = 1'b0;
        ld_vert   = 1'b0;
        ld_horz   = 1'b0;
        tour_done = 1'b0;
        case (state)
            IDLE: begin
                if (start_tour) begin
                    state_n  = LOAD;
                    clr_indx = 1'b1;
                end
            end
            LOAD: begin
                if (move == 8'h00) begin
                    state_n = IDLE;
                end else begin
                    state_n = VERT;
                    ld_vert = 1'b1;
                end
            end
            VERT: begin
                if (clr_cmd_rdy && send_resp) begin
                    state_n = HORZ;
                    ld_horz = 1'b1;
                end else if (clr_cmd_rdy) begin
                    state_n = VWAIT;
                end
            end
            VWAIT: begin
                if (send_resp) begin
                    state_n = HORZ;
                    ld_horz = 1'b1;
                end
            end
            HORZ, HWAIT: begin
                if ((state == HWAIT && send_resp) ||
                    (state == HORZ && clr_cmd_rdy && send_resp)) begin
                    if (mv_indx == LAST_INDX) begin
                        state_n   = IDLE;
                        tour_done = 1'b1;
                    end else begin
                        state_n  = LOAD;
                        inc_indx = 1'b1;
                    end
                end else if (state == HORZ && clr_cmd_rdy) begin
                    state_n = HWAIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, move index, latched move and the registered FSM command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mv_indx     <= 5'd0;
            mv_reg      <= 8'h00;
            cmd_fsm     <= 16'h0000;
            cmd_rdy_fsm <= 1'b0;
        end else begin
            state       <= state_n;
            cmd_rdy_fsm <= (state_n == VERT) || (state_n == HORZ);
            if (clr_indx) begin
                mv_indx <= 5'd0;
            end else if (inc_indx) begin
                mv_indx <= mv_indx + 5'd1;
            end
            if (ld_vert) begin
                mv_reg  <= move;
                cmd_fsm <= vert_cmd(move);
            end else if (ld_horz) begin
                cmd_fsm <= horz_cmd(mv_reg);
            end
        end
    end

    // UART passthrough while idle; the tour owns the command port otherwise.
    always_comb begin
        cmd     = (state == IDLE) ? cmd_UART : cmd_fsm;
        cmd_rdy = (state == IDLE) ? cmd_rdy_UART : cmd_rdy_fsm;
        resp    = (state != IDLE && !tour_done) ? RESP_BUSY : RESP_DONE;
    end

endmodule
